// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg
//   Shared definitions for the ROM burst reader slice.
//   - state_e           : burst FSM states (IDLE, FETCH, DRAIN)
//   - DEF_* localparams : default values for the reader parameters
//   - FIFO_DEPTH        : number of entries in the output word FIFO
package rom_reader_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK       = 4;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_reader_fifo2.sv
// rom_reader_fifo2
//   Two-entry valid/ready FIFO holding assembled output words.
//   Ports:
//     clk          in   clock, rising edge
//     RESETn       in   asynchronous active-low reset (empties FIFO, zeroes storage)
//     push_valid_i in   write one entry this clock (caller guarantees room)
//     push_data_i  in   entry to write
//     pop_valid_o  out  head entry is valid
//     pop_ready_i  in   consumer takes the head entry
//     pop_data_o   out  head entry, stable until popped
//     count_o      out  current occupancy (0..2)
module rom_reader_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             RESETn,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             pop;

  assign pop         = pop_ready_i && (count_q != 2'd0);
  assign pop_valid_o = (count_q != 2'd0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Storage and pointers. A push and a pop in the same clock leave the
  // occupancy unchanged; storage is zeroed on reset so the head reads 0.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_valid_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_valid_i, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader
//   Reads len*PACK consecutive ROM words starting at base_addr and packs
//   every PACK of them into one output word delivered over valid/ready.
//   Ports:
//     clk        in   clock, rising edge
//     RESETn     in   asynchronous active-low reset, abandons any burst
//     req        in   burst request, sampled only while idle
//     base_addr  in   first ROM address (sampled with req)
//     len        in   number of output words (sampled with req, 0 = no-op)
//     idle       out  high when a request can be accepted
//     rom_cen    out  ROM read enable
//     rom_addr   out  ROM read address
//     rom_data   in   ROM data, valid one clock after rom_cen
//     out_valid  out  output word valid
//     out_ready  in   output word accepted
//     out_data   out  packed output word
//     out_last   out  final word of the burst
//     done       out  one-clock pulse at burst completion
//   Build option: define ROM_READER_BIG_ENDIAN_EN to place the first ROM
//   word of each output word in the MSBs (default: in the LSBs).
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK       = DEF_PACK,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       RESETn,
  input  logic                       req,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [LEN_WIDTH-1:0]       len,
  output logic                       idle,
  output logic                       rom_cen,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0]      rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK*DATA_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       done
);

  localparam int               WORD_W   = PACK * DATA_WIDTH;
  localparam int               IDX_W    = $clog2(PACK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   issue_left_q;
  logic [LEN_WIDTH-1:0]   push_left_q;
  logic [IDX_W-1:0]       issue_idx_q;
  logic [IDX_W-1:0]       cap_idx_q;
  logic [IDX_W-1:0]       slot;
  logic                   cap_valid_q;
  logic [1:0]             open_q;
  logic [WORD_W-1:0]      buf_q;
  logic [WORD_W-1:0]      word_d;
  logic                   done_q;
  logic [2:0]             committed;
  logic                   accept, zero_req;
  logic                   issue_first, issue_last;
  logic                   push, push_last, pop_last_fire;
  logic [1:0]             fifo_count;
  logic [WORD_W:0]        pop_word;

  assign accept    = (state_q == IDLE) && req && (len != '0);
  assign zero_req  = (state_q == IDLE) && req && (len == '0);
  assign idle      = (state_q == IDLE);
  assign rom_addr  = addr_q;
  assign done      = done_q;

  // A word is reserved when its first read issues: FIFO entries plus words
  // still being assembled must leave room for it. Later reads of the same
  // word are always allowed, so no issued read can ever be dropped.
  assign committed   = {1'b0, fifo_count} + {1'b0, open_q};
  assign rom_cen     = (state_q == FETCH) &&
                       ((issue_idx_q != '0) || (committed <= 3'd1));
  assign issue_first = rom_cen && (issue_idx_q == '0);
  assign issue_last  = rom_cen && (issue_idx_q == LAST_IDX);

  assign push          = cap_valid_q && (cap_idx_q == LAST_IDX);
  assign push_last     = (push_left_q == LEN_WIDTH'(1));
  assign pop_last_fire = out_valid && out_ready && out_last;

  // Merge the byte arriving this clock into the partial word; on the final
  // byte this is the complete word pushed into the FIFO.
  always_comb begin
`ifdef ROM_READER_BIG_ENDIAN_EN
    slot = LAST_IDX - cap_idx_q;
`else
    slot = cap_idx_q;
`endif
    word_d = buf_q;
    word_d[slot*DATA_WIDTH +: DATA_WIDTH] = rom_data;
  end

  // Burst FSM: FETCH until the last read issues, DRAIN until the last word
  // leaves the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (issue_last && (issue_left_q == LEN_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   if (pop_last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/issue counters, capture pipeline and word assembly. Reset clears
  // cap_valid_q so a read in flight at reset is never captured.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      addr_q       <= '0;
      issue_left_q <= '0;
      push_left_q  <= '0;
      issue_idx_q  <= '0;
      cap_idx_q    <= '0;
      cap_valid_q  <= 1'b0;
      open_q       <= 2'd0;
      buf_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      cap_valid_q <= rom_cen;
      done_q      <= zero_req || pop_last_fire;
      case ({issue_first, push})
        2'b10:   open_q <= open_q + 2'd1;
        2'b01:   open_q <= open_q - 2'd1;
        default: open_q <= open_q;
      endcase
      if (accept) begin
        addr_q       <= base_addr;
        issue_left_q <= len;
        push_left_q  <= len;
        issue_idx_q  <= '0;
        cap_idx_q    <= '0;
      end else begin
        if (rom_cen) begin
          addr_q      <= addr_q + 1'b1;
          issue_idx_q <= issue_last ? '0 : issue_idx_q + 1'b1;
          if (issue_last) begin
            issue_left_q <= issue_left_q - 1'b1;
          end
        end
        if (cap_valid_q) begin
          cap_idx_q <= (cap_idx_q == LAST_IDX) ? '0 : cap_idx_q + 1'b1;
          buf_q     <= word_d;
        end
        if (push) begin
          push_left_q <= push_left_q - 1'b1;
        end
      end
    end
  end

  rom_reader_fifo2 #(
    .WIDTH(WORD_W + 1)
  ) u_fifo (
    .clk          (clk),
    .RESETn       (RESETn),
    .push_valid_i (push),
    .push_data_i  ({push_last, word_d}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (pop_word),
    .count_o      (fifo_count)
  );

  assign out_data = pop_word[WORD_W-1:0];
  assign out_last = pop_word[WORD_W];

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader
//   Directed bench for rom_burst_reader at default parameters. A ROM model
//   returns ROM[n] = n & 0xFF one clock after rom_cen; monitors log issued
//   addresses, accepted output words and done pulses. Expected packing
//   follows ROM_READER_BIG_ENDIAN_EN when the bench is built with it.
module tb_rom_burst_reader;

  logic        clk = 1'b0;
  logic        RESETn;
  logic        req;
  logic [14:0] base_addr;
  logic [7:0]  len;
  logic        idle;
  logic        rom_cen;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;

  int          checks   = 0;
  int          failures = 0;
  int          doneCount = 0;
  int          doneSnap;
  logic [14:0] addrLog [$];
  logic [31:0] outLog  [$];
  logic        lastLog [$];
  logic [31:0] heldWord;

  rom_burst_reader dut (
    .clk       (clk),
    .RESETn    (RESETn),
    .req       (req),
    .base_addr (base_addr),
    .len       (len),
    .idle      (idle),
    .rom_cen   (rom_cen),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM model plus monitors for reads, accepted words and done pulses.
  always @(posedge clk) begin
    if (rom_cen) begin
      rom_data <= rom_addr[7:0];
      addrLog.push_back(rom_addr);
    end
    if (out_valid && out_ready) begin
      outLog.push_back(out_data);
      lastLog.push_back(out_last);
    end
    if (done) doneCount++;
  end

  function automatic logic [31:0] expWord(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
`ifdef ROM_READER_BIG_ENDIAN_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request for one clock; returns #1 after the acceptance edge.
  task automatic applyStimulus(input logic [14:0] b, input logic [7:0] l);
    base_addr = b;
    len       = l;
    req       = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic stepClock(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (!idle && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, {31'd0, idle}, 32'd1);
  endtask

  task automatic clearLogs();
    addrLog.delete();
    outLog.delete();
    lastLog.delete();
    doneSnap = doneCount;
  endtask

  initial begin
    RESETn    = 1'b1;
    req       = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b1;
    #2 RESETn = 1'b0;
    stepClock(3);

    // Reset state
    checkOutput("rst_idle",      {31'd0, idle},      32'd1);
    checkOutput("rst_rom_cen",   {31'd0, rom_cen},   32'd0);
    checkOutput("rst_rom_addr",  {17'd0, rom_addr},  32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data",  out_data,           32'd0);
    checkOutput("rst_out_last",  {31'd0, out_last},  32'd0);
    checkOutput("rst_done",      {31'd0, done},      32'd0);
    RESETn = 1'b1;
    stepClock(1);

    // Basic single-word burst with latency checks
    clearLogs();
    applyStimulus(15'h0100, 8'd1);
    checkOutput("b031_idle_low",  {31'd0, idle},     32'd0);
    checkOutput("b031_first_cen", {31'd0, rom_cen},  32'd1);
    checkOutput("b031_first_addr",{17'd0, rom_addr}, 32'h0100);
    stepClock(1);
    checkOutput("b031_second_addr",{17'd0, rom_addr}, 32'h0101);
    stepClock(3);
    checkOutput("b031_not_valid_yet", {31'd0, out_valid}, 32'd0);
    stepClock(1);
    checkOutput("b031_valid",  {31'd0, out_valid}, 32'd1);
    checkOutput("b031_data",   out_data, expWord(8'h00, 8'h01, 8'h02, 8'h03));
    checkOutput("b031_last",   {31'd0, out_last},  32'd1);
    checkOutput("b031_done_early", {31'd0, done},  32'd0);
    stepClock(1);
    checkOutput("b031_done",   {31'd0, done},      32'd1);
    checkOutput("b031_idle",   {31'd0, idle},      32'd1);
    checkOutput("b031_drained",{31'd0, out_valid}, 32'd0);
    stepClock(1);
    checkOutput("b031_done_pulse", {31'd0, done}, 32'd0);
    checkOutput("b031_reads", addrLog.size(), 32'd4);

    // Zero-length request
    clearLogs();
    applyStimulus(15'h0050, 8'd0);
    checkOutput("b034_idle", {31'd0, idle}, 32'd1);
    checkOutput("b034_done", {31'd0, done}, 32'd1);
    stepClock(1);
    checkOutput("b034_done_pulse", {31'd0, done}, 32'd0);
    stepClock(5);
    checkOutput("b034_no_reads",  addrLog.size(), 32'd0);
    checkOutput("b034_done_once", doneCount - doneSnap, 32'd1);
    checkOutput("b034_idle_held", {31'd0, idle}, 32'd1);

    // Address wrap at the top of the ROM
    clearLogs();
    applyStimulus(15'h7FFE, 8'd1);
    waitIdle("b032_timeout", 50);
    stepClock(1);
    checkOutput("b032_reads", addrLog.size(), 32'd4);
    if (addrLog.size() == 4) begin
      checkOutput("b032_addr0", {17'd0, addrLog[0]}, 32'h7FFE);
      checkOutput("b032_addr1", {17'd0, addrLog[1]}, 32'h7FFF);
      checkOutput("b032_addr2", {17'd0, addrLog[2]}, 32'h0000);
      checkOutput("b032_addr3", {17'd0, addrLog[3]}, 32'h0001);
    end
    checkOutput("b032_words", outLog.size(), 32'd1);
    if (outLog.size() == 1) begin
      checkOutput("b032_data", outLog[0], expWord(8'hFE, 8'hFF, 8'h00, 8'h01));
      checkOutput("b032_last", {31'd0, lastLog[0]}, 32'd1);
    end
    checkOutput("b032_done_once", doneCount - doneSnap, 32'd1);

    // Back-pressure: two words buffer, then the ROM stalls
    clearLogs();
    out_ready = 1'b0;
    applyStimulus(15'h0010, 8'd4);
    stepClock(10);
    heldWord = out_data;
    checkOutput("b033_head_c10", heldWord, expWord(8'h10, 8'h11, 8'h12, 8'h13));
    stepClock(10);
    checkOutput("b033_head_c20",  out_data, expWord(8'h10, 8'h11, 8'h12, 8'h13));
    checkOutput("b033_valid",     {31'd0, out_valid}, 32'd1);
    checkOutput("b033_last_low",  {31'd0, out_last},  32'd0);
    checkOutput("b033_stalled",   {31'd0, rom_cen},   32'd0);
    checkOutput("b033_stall_reads", addrLog.size(), 32'd8);
    out_ready = 1'b1;
    waitIdle("b033_timeout", 200);
    stepClock(1);
    checkOutput("b033_words", outLog.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (outLog.size() > i) begin
        checkOutput($sformatf("b033_word%0d", i), outLog[i],
                    expWord(8'(16 + 4*i), 8'(17 + 4*i), 8'(18 + 4*i), 8'(19 + 4*i)));
        checkOutput($sformatf("b033_last%0d", i), {31'd0, lastLog[i]},
                    (i == 3) ? 32'd1 : 32'd0);
      end
    end
    checkOutput("b033_total_reads", addrLog.size(), 32'd16);
    checkOutput("b033_done_once", doneCount - doneSnap, 32'd1);

    // Reset in the middle of a burst, then a fresh burst
    applyStimulus(15'h0300, 8'd4);
    stepClock(2);
    RESETn = 1'b0;
    #1;
    checkOutput("b035_rst_idle",  {31'd0, idle},      32'd1);
    checkOutput("b035_rst_cen",   {31'd0, rom_cen},   32'd0);
    checkOutput("b035_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("b035_rst_addr",  {17'd0, rom_addr},  32'd0);
    stepClock(2);
    RESETn = 1'b1;
    clearLogs();
    stepClock(1);
    applyStimulus(15'h0200, 8'd1);
    waitIdle("b035_timeout", 50);
    stepClock(3);
    checkOutput("b035_words", outLog.size(), 32'd1);
    if (outLog.size() == 1) begin
      checkOutput("b035_data", outLog[0], expWord(8'h00, 8'h01, 8'h02, 8'h03));
      checkOutput("b035_last", {31'd0, lastLog[0]}, 32'd1);
    end
    checkOutput("b035_reads", addrLog.size(), 32'd4);
    if (addrLog.size() > 0) begin
      checkOutput("b035_addr0", {17'd0, addrLog[0]}, 32'h0200);
    end
    checkOutput("b035_done_once", doneCount - doneSnap, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_burst_reader.md
ROM_BURST_READER -- requirements
Module: rom_burst_reader

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 15, ROM address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, ROM data width.
REQ-003 SHALL provide parameter PACK, default 4, ROM words per output word (2..8).
REQ-004 SHALL provide parameter LEN_WIDTH, default 8, burst length counter width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, rising edge; RESETn  in  1  asynchronous active-low reset.
REQ-006 SHALL provide req  in  1  burst request, sampled when idle.
REQ-007 SHALL provide base_addr  in  ADDR_WIDTH  first ROM address, sampled with req.
REQ-008 SHALL provide len  in  LEN_WIDTH  output words to deliver, sampled with req.
REQ-009 SHALL provide idle  out  1  high when a request can be accepted.
REQ-010 SHALL provide rom_cen  out  1  ROM read enable.
REQ-011 SHALL provide rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-012 SHALL provide rom_data  in  DATA_WIDTH  ROM read data, valid one clock after rom_cen.
REQ-013 SHALL provide out_valid  out  1, out_ready  in  1, out_data  out  PACK*DATA_WIDTH, out_last  out  1  output stream.
REQ-014 SHALL provide done  out  1  one-clock pulse at burst completion.

Function
REQ-015 FSM SHALL have states IDLE, FETCH, DRAIN; idle high only in IDLE.
REQ-016 IDLE->FETCH on req with len!=0; req with len==0 SHALL stay IDLE and pulse done next clock with no ROM read; req outside IDLE SHALL be ignored.
REQ-017 In FETCH, each clock with rom_cen high SHALL issue one read at rom_addr, then increment rom_addr modulo 2**ADDR_WIDTH (wrap 0x7FFF->0x0000 at default).
REQ-018 rom_data SHALL be captured exactly one clock after its rom_cen cycle; rom_cen low SHALL hold rom_addr.
REQ-019 PACK consecutive captured bytes SHALL form one output word, pushed into a 2-entry output FIFO.
REQ-020 A read SHALL be issued only if FIFO occupancy plus words already completed-in-flight stays <=2 once its word completes; FIFO SHALL never overflow and no read is ever discarded.
REQ-021 Unstalled latency: first rom_cen in the clock after acceptance; first out_valid PACK+1 clocks after the acceptance edge; one ROM read per clock thereafter while out_ready high.
REQ-022 After len*PACK reads, FETCH->DRAIN; DRAIN->IDLE when the final word is accepted.
REQ-023 out_last SHALL be high only with the final word; out_data/out_last SHALL hold stable while out_valid high and out_ready low.
REQ-024 done SHALL pulse in the clock after out_valid&&out_ready&&out_last.
REQ-025 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.

Reset
REQ-026 While RESETn low: state IDLE, idle=1, rom_cen=0, rom_addr=0, out_valid=0, out_data=0, out_last=0, done=0, FIFO empty, counters 0.
REQ-027 Reset mid-burst SHALL abandon the burst immediately; in-flight data SHALL not appear after reset release.

Configuration
REQ-028 Macro ROM_READER_BIG_ENDIAN_EN defined: first byte of each word in out_data MSBs; undefined: first byte in bits [DATA_WIDTH-1:0].

Structure
REQ-029 Package rom_reader_pkg SHALL hold the state enum and parameter defaults.
REQ-030 The output FIFO SHALL be sub-module rom_reader_fifo2 (2-entry, valid/ready, occupancy output).

Verification
REQ-031 base=0x0100, len=1, ROM[n]=n&0xFF, out_ready=1 -> out_data=0x03020100 (LE), out_last=1, 5 clocks after acceptance; done next clock.
REQ-032 base=0x7FFE, len=1 -> reads 0x7FFE,0x7FFF,0x0000,0x0001; out_data=0x0100FFFE.
REQ-033 len=4, out_ready low 20 clocks -> rom_cen stalls with 2 words buffered; release -> 4 words in order, none lost or duplicated.
REQ-034 len=0 -> no rom_cen, done pulses once, idle stays 1.
REQ-035 RESETn low mid-FETCH, then new req base=0x0200, len=1 -> only 0x03020100+0x0200 pattern word (0x03020100 shifted to ROM[0x200..]) delivered, no stale word.
REQ-036 ROM_READER_BIG_ENDIAN_EN defined, REQ-031 stimulus -> out_data=0x00010203.
